// File: rtl/rtl_shift_reg_pkg.sv
// ---------------------------------------------------------------------------
// rtl_shift_reg_pkg
//
// Shared definitions for the universal shift register slice.
//
// Contents:
//   DEFAULT_WIDTH  - register width used when the top is not overridden
//   MIN_WIDTH      - smallest supported register width
//   MAX_WIDTH      - largest supported register width
//   mode_e         - single operating mode chosen for a clock cycle
//   decode_mode()  - priority decode of the ld/sr/sl controls into mode_e
// ---------------------------------------------------------------------------
package rtl_shift_reg_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 32;

    // One mode per cycle. Every cell in the register sees the same value,
    // so the whole word always moves in lockstep.
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SL   = 2'b01,
        MODE_SR   = 2'b10,
        MODE_LD   = 2'b11
    } mode_e;

    // Priority is ld > sr > sl > hold. Each test is a plain if-condition,
    // so an unknown control evaluates as false in simulation and falls
    // through to the next, lower-priority choice. Only a control that is
    // genuinely 1 can start an action.
    function automatic mode_e decode_mode(
        input logic ld,
        input logic sr,
        input logic sl
    );
        mode_e mode;
        mode = MODE_HOLD;
        if (ld) begin
            mode = MODE_LD;
        end else if (sr) begin
            mode = MODE_SR;
        end else if (sl) begin
            mode = MODE_SL;
        end
        return mode;
    endfunction

endpackage : rtl_shift_reg_pkg

// File: rtl/rtl_shift_cell.sv
// ---------------------------------------------------------------------------
// rtl_shift_cell
//
// One bit of the universal shift register. A 4:1 mux picks the next value
// of the bit, and one asynchronously reset flop stores it.
//
// Ports:
//   clk    in   clock, rising edge active
//   rst_n  in   asynchronous active-low reset, clears the bit to 0
//   mode   in   operating mode shared by all cells
//   sl_in  in   bit that moves into this cell on a left shift
//               (lower neighbour's q, or D_sl at the LSB)
//   sr_in  in   bit that moves into this cell on a right shift
//               (upper neighbour's q, or D_sr at the MSB)
//   d_in   in   this cell's bit of the parallel load word
//   q      out  stored bit, taken straight from the flop
// ---------------------------------------------------------------------------
module rtl_shift_cell
    import rtl_shift_reg_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  mode_e mode,
    input  logic  sl_in,
    input  logic  sr_in,
    input  logic  d_in,
    output logic  q
);

    logic q_next;

    // Next-value mux. Hold recirculates the flop output, so the flop is
    // written on every edge and needs no separate enable.
    always_comb begin
        q_next = q;
        unique case (mode)
            MODE_HOLD: q_next = q;
            MODE_SL:   q_next = sl_in;
            MODE_SR:   q_next = sr_in;
            MODE_LD:   q_next = d_in;
            default:   q_next = q;
        endcase
    end

    // Storage flop. Reset clears it at once, independent of clk, and
    // wins over anything the mux is presenting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= q_next;
        end
    end

endmodule : rtl_shift_cell

// File: rtl/rtl_shift_reg.sv
// ---------------------------------------------------------------------------
// rtl_shift_reg
//
// WIDTH-bit universal shift register: parallel load, shift right, shift
// left and hold, with priority ld > sr > sl > hold. All updates happen on
// the rising edge of clk; Q comes straight from flops.
//
// Parameters:
//   WIDTH  register width in bits, supported range 2..32
//
// Ports:
//   clk    in   clock, rising edge active
//   rst_n  in   asynchronous active-low reset, clears Q to 0
//   ld     in   parallel load enable (highest priority)
//   sr     in   shift right enable
//   sl     in   shift left enable (lowest priority)
//   D_sr   in   serial bit entering the MSB on a right shift
//   D_sl   in   serial bit entering the LSB on a left shift
//   D      in   parallel load data, WIDTH bits
//   Q      out  register contents, WIDTH bits
// ---------------------------------------------------------------------------
module rtl_shift_reg
    import rtl_shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic             sr,
    input  logic             sl,
    input  logic             D_sr,
    input  logic             D_sl,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    mode_e mode;

    // One decoder for the whole register, so every cell agrees on the
    // operation for this cycle.
    always_comb begin
        mode = decode_mode(ld, sr, sl);
    end

    // One cell per bit. Each cell gets its two shift neighbours: on a left
    // shift bit i takes bit i-1, on a right shift it takes bit i+1. At the
    // ends of the word the missing neighbour is replaced by the matching
    // serial input. The bit pushed out the far end is not fed back, so
    // shifting never wraps.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic sl_src;
        logic sr_src;

        if (i == 0) begin : g_lsb
            assign sl_src = D_sl;
        end else begin : g_sl_mid
            assign sl_src = Q[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign sr_src = D_sr;
        end else begin : g_sr_mid
            assign sr_src = Q[i+1];
        end

        rtl_shift_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .mode  (mode),
            .sl_in (sl_src),
            .sr_in (sr_src),
            .d_in  (D[i]),
            .q     (Q[i])
        );
    end

endmodule : rtl_shift_reg

// File: tb/tb_rtl_shift_reg.sv
// ---------------------------------------------------------------------------
// tb_rtl_shift_reg
//
// Self-checking bench for rtl_shift_reg at WIDTH=4. Directed steps cover
// reset, priority, shifting, hold and full shift-out; a randomized phase
// compares Q against an arithmetic model of the register.
// ---------------------------------------------------------------------------
module tb_rtl_shift_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             ld;
    logic             sr;
    logic             sl;
    logic             D_sr;
    logic             D_sl;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;

    int assert_count;
    int fail_count;
    int model_q;

    rtl_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ld   (ld),
        .sr   (sr),
        .sl   (sl),
        .D_sr (D_sr),
        .D_sl (D_sl),
        .D    (D),
        .Q    (Q)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upper bound on run time so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference behaviour from the register's rules, using integer
    // arithmetic on the value: halving drops the LSB, doubling modulo
    // 2**WIDTH drops the MSB.
    function automatic int model_next(input int q, input logic l, input logic r,
                                      input logic s, input logic dr, input logic dl,
                                      input int d);
        int full;
        full = 1 << WIDTH;
        if (l === 1'b1) return d % full;
        if (r === 1'b1) return q / 2 + int'(dr) * (full / 2);
        if (s === 1'b1) return (q * 2 + int'(dl)) % full;
        return q;
    endfunction

    // Compare Q against an expected value and record the outcome.
    task automatic check_output(input string tag, input int expected);
        logic [WIDTH-1:0] exp_v;
        exp_v = WIDTH'(expected);
        assert_count++;
        assert (Q === exp_v) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed Q=%b expected Q=%b", tag, Q, exp_v);
        end
    endtask

    // Drive one cycle of controls at the falling edge, let the rising edge
    // act, and advance the model. Returns #1 after the rising edge.
    task automatic apply_stimulus(input logic l, input logic r, input logic s,
                                  input logic dr, input logic dl, input int d);
        @(negedge clk);
        ld   = l;
        sr   = r;
        sl   = s;
        D_sr = dr;
        D_sl = dl;
        D    = WIDTH'(d);
        @(posedge clk);
        model_q = model_next(model_q, l, r, s, dr, dl, d);
        #1;
    endtask

    initial begin
        assert_count = 0;
        fail_count   = 0;
        model_q      = 0;
        rst_n = 1'b0;
        ld    = 1'b0;
        sr    = 1'b0;
        sl    = 1'b0;
        D_sr  = 1'b0;
        D_sl  = 1'b0;
        D     = '0;

        // Reset state
        #3;
        check_output("reset_init", 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset between edges, and reset dominating load
        apply_stimulus(1, 0, 0, 0, 0, 4'b1111);
        check_output("load_ones", 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_clear", 0);
        model_q = 0;
        @(negedge clk);
        ld = 1'b1;
        D  = 4'b1111;
        @(posedge clk);
        #1;
        check_output("reset_holds_zero", 0);
        @(negedge clk);
        ld    = 1'b0;
        rst_n = 1'b1;

        // Load beats shift right
        apply_stimulus(1, 1, 0, 1, 1, 4'b1010);
        check_output("load_beats_sr", 4'b1010);

        // Shift right with serial input
        apply_stimulus(0, 1, 0, 1, 0, 4'b0000);
        check_output("sr_in_one", 4'b1101);
        apply_stimulus(0, 1, 0, 0, 1, 4'b1111);
        check_output("sr_in_zero", 4'b0110);

        // Shift left, then shift right beating shift left
        apply_stimulus(1, 0, 0, 0, 0, 4'b1010);
        apply_stimulus(0, 0, 1, 1, 0, 4'b0101);
        check_output("sl_in_zero", 4'b0100);
        apply_stimulus(1, 0, 0, 0, 0, 4'b1010);
        apply_stimulus(0, 1, 1, 0, 1, 4'b1111);
        check_output("sr_beats_sl", 4'b0101);

        // Hold with data and serial inputs toggling
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 0, 0, i[0], ~i[0], (i % 2 == 0) ? 4'b1010 : 4'b1111);
            check_output("hold", 4'b0101);
        end

        // Full shift-out to the left, no wrap
        apply_stimulus(1, 0, 0, 0, 0, 4'b1111);
        apply_stimulus(0, 0, 1, 1, 0, 0);
        check_output("shift_out_1", 4'b1110);
        apply_stimulus(0, 0, 1, 1, 0, 0);
        check_output("shift_out_2", 4'b1100);
        apply_stimulus(0, 0, 1, 1, 0, 0);
        check_output("shift_out_3", 4'b1000);
        apply_stimulus(0, 0, 1, 1, 0, 0);
        check_output("shift_out_4", 4'b0000);

        // Randomized traffic against the model, with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                model_q = 0;
                check_output("rand_async_clear", model_q);
                @(posedge clk);
                #1;
                check_output("rand_reset_hold", model_q);
                @(negedge clk);
                ld    = 1'b0;
                sr    = 1'b0;
                sl    = 1'b0;
                rst_n = 1'b1;
            end
            apply_stimulus(($urandom_range(0, 4) == 0),
                           ($urandom_range(0, 2) == 0),
                           ($urandom_range(0, 1) == 0),
                           1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)),
                           int'($urandom_range(0, (1 << WIDTH) - 1)));
            check_output("rand_step", model_q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule : tb_rtl_shift_reg
